// File: rtl/mux_pkg.sv
// Shared helpers for the round-robin multiplexer: index width and
// reset-priority derivations, both as functions of the channel count.
package mux_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int sel_w(input int num_ch);
    return (clog2(num_ch) > 1) ? clog2(num_ch) : 1;
  endfunction

  // last_grant value after reset: the highest channel, so the search
  // starting at last_grant+1 lands on channel 0 first.
  function automatic int rr_rst_last(input int num_ch);
    return num_ch - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches the masked request vector
// starting one past last_grant and wrapping at NUM_CH; the first hit wins.
// Indices >= NUM_CH never exist in the search, so grant is always < NUM_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  logic [NUM_CH-1:0] eff_req;

  assign eff_req   = req & mask;
  assign grant_vld = |eff_req;

  // Walk offsets from farthest to nearest so the nearest requester is the
  // last (and therefore winning) assignment.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (eff_req[idx]) begin
        grant = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel round-robin multiplexer with valid/ready on every input and a
// one-stage registered output.
// Optional feature macro: MUX_RR_SEL_OVERRIDE_EN adds force_en/force_sel,
// which restrict the grant to one channel while force_en is high.
//
// Handshake: a beat moves on any interface only on a rising edge where
// valid && ready are both high. Producers hold valid and data stable until
// accepted. in_ready depends only on the output stage being able to load
// (load = !out_valid || out_ready) and on the arbiter's grant, never on
// valid of a channel except through that grant.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
`ifdef MUX_RR_SEL_OVERRIDE_EN
  ,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel
`endif
);

  logic [SEL_W-1:0]  last_grant;
  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic [NUM_CH-1:0] grant_mask;
  logic [WIDTH-1:0]  sel_data;
  logic              load;

  assign load = !out_valid || out_ready;

`ifdef MUX_RR_SEL_OVERRIDE_EN
  // Forcing leaves only the selected channel eligible; an out-of-range
  // force_sel matches no bit and so grants nothing.
  always_comb begin
    grant_mask = '1;
    if (force_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        grant_mask[i] = (force_sel == SEL_W'(i));
      end
    end
  end
`else
  assign grant_mask = '1;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req        (in_valid),
    .mask       (grant_mask),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  // One-hot accept for the granted channel, only when the output can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = load && grant_vld && (grant == SEL_W'(i));
    end
  end

  // Data path mux driven by the grant index.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and priority pointer; the pointer moves only on a
  // transfer so idle cycles do not rotate priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(rr_rst_last(NUM_CH));
    end else if (load) begin
      if (grant_vld) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_sel    <= grant;
        last_grant <= grant;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed, table-driven bench for mux_rr_n (WIDTH=8, NUM_CH=4).
// Channel i always presents data 8'h10+i.
module tb_mux_rr_n;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_sel;
  logic                    out_ready;
`ifdef MUX_RR_SEL_OVERRIDE_EN
  logic                    force_en;
  logic [1:0]              force_sel;
`endif

  mux_rr_n #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_RR_SEL_OVERRIDE_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [7:0] od;
    logic [1:0] os;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  // Drive one cycle: inputs just after an edge, check in_ready before the
  // next edge, then check the registered outputs 1ns after that edge.
  task automatic step(input string tag, input logic [3:0] iv, input logic ordy,
                      input logic [3:0] ir, input logic ov, input logic [7:0] od,
                      input logic [1:0] os);
    in_valid  = iv;
    out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"}, 32'(out_data), 32'(od));
    check({tag, ".out_sel"}, 32'(out_sel), 32'(os));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_data[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
    end
    in_valid  = '0;
    out_ready = 1'b0;
`ifdef MUX_RR_SEL_OVERRIDE_EN
    force_en  = 1'b0;
    force_sel = 2'd0;
`endif

    //            iv       rdy   ir       ov    od     os
    // full-rate rotation from reset priority (ch0 first)
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    // back-pressure for three cycles: beat held, nothing accepted
    vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    // release: next round-robin channel (ch1), old beat leaves same edge
    vecs[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // single requester ch2: granted every cycle, no bubbles
    vecs[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[10] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    // grant ch1, then idle: out_valid drops, data/sel hold, priority holds
    vecs[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    // 1011 after last_grant=1: ch3 first, then wrap to ch0
    vecs[18] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[19] = '{4'b1011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[20] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    vecs[21] = '{4'b1011, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // empty stage loads even with out_ready low
    vecs[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[23] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[24] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};

    // reset and its values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.out_sel", 32'(out_sel), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      step($sformatf("vec%0d", v), vecs[v].iv, vecs[v].ordy, vecs[v].ir,
           vecs[v].ov, vecs[v].od, vecs[v].os);
    end

    // reset mid-operation: beat in flight, ch2 pending, consumer stalled
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #2;
    check("mid.pre_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid.async_out_valid", 32'(out_valid), 32'd0);
    check("mid.async_out_data", 32'(out_data), 32'd0);
    check("mid.async_out_sel", 32'(out_sel), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    // priority back at ch0
    step("post_rst0", 4'b0101, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    step("post_rst1", 4'b0101, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    step("post_rst2", 4'b0101, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);

`ifdef MUX_RR_SEL_OVERRIDE_EN
    // forced channel 3: only ch3 accepted while it requests
    force_en  = 1'b1;
    force_sel = 2'd3;
    step("force0", 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    step("force1", 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    step("force2", 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
    // forced channel not requesting: nothing accepted
    step("force3", 4'b0111, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3);
    force_en = 1'b0;
    // back to round-robin after last_grant=3
    step("force4", 4'b0111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
`endif

    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a valid/ready handshake on every input and on the output. It replaces a fixed combinational 2:1 select with round-robin arbitration and a one-stage output register. It sits between several producers and one shared consumer, such as a bus or UART TX, and gives each requesting channel fair access and back-pressure.

Parameters:
WIDTH, 8, data bits per channel
NUM_CH, 4, number of input channels; must be >= 2
SEL_W, derived = max(1, clog2(NUM_CH)), width of the channel index (localparam, not overridable)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i
in_data  input  NUM_CH*WIDTH  flattened data; channel i occupies [i*WIDTH +: WIDTH]
in_ready  output  NUM_CH  per-channel accept, one-hot or zero
out_valid  output  1  output register holds a beat
out_data  output  WIDTH  registered data
out_sel  output  SEL_W  index of the channel that produced out_data
out_ready  input  1  consumer accept

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, internal last_grant=NUM_CH-1, so channel 0 has first priority after reset.
- Load condition: load = !out_valid || out_ready. This is a pipeline-ready stage, so full throughput is 1 beat/cycle.
- Arbitration (combinational):
  - Search in_valid starting at last_grant+1 and wrapping modulo NUM_CH.
  - The first set bit is the grant; grant_vld = |in_valid.
- Handshake: in_ready[i] = load && grant_vld && (grant==i).
  - in_ready never depends on in_valid of other channels except through the grant.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer (rising edge):
  - out_data <= channel data; out_sel <= grant; out_valid <= 1; last_grant <= grant.
- On load with no request: out_valid <= 0. out_data and out_sel hold their last values.
- When !load: all registers hold and in_ready=0. Producers must keep valid and data stable until accepted.
- Latency: input accepted on edge k; data visible on out_data after edge k; consumed on the first edge with out_ready=1.
- last_grant changes only on a transfer. An idle cycle does not rotate priority.
- Wrap-around: grant at NUM_CH-1 makes channel 0 next in priority.
- Single requester: it is granted every cycle (no forced bubbles).
- Simultaneous out_ready=1 and a new grant: the old beat leaves and the new beat loads in the same edge.
- Reset mid-operation: the in-flight beat is dropped, out_valid=0 immediately (async), and priority returns to channel 0.
- NUM_CH not a power of two: indices >= NUM_CH are never granted. out_sel is always < NUM_CH.

Optional Feature:
Macro: MUX_RR_SEL_OVERRIDE_EN
- Defined: adds two input ports, force_en (1 bit) and force_sel (SEL_W bits). While force_en=1, only channel force_sel can be granted; it is granted iff in_valid[force_sel]. last_grant still updates on a transfer. A force_sel >= NUM_CH grants nothing.
- Undefined: the ports do not exist and pure round-robin applies.

Decomposition:
- Package mux_pkg:
  - clog2 function
  - SEL_W derivation rule
  - reset-priority constant RR_RST_LAST = NUM_CH-1 (expressed as a function of NUM_CH)
- Sub-module rr_arbiter (NUM_CH): inputs req, last_grant, optional force mask; outputs grant index and grant_vld. It is purely combinational.
- mux_rr_n owns the last_grant register, the output register and the handshake.

Test Plan:
- Reset then all in_valid=4'b1111, out_ready=1, data ch i = 8'h10+i -> out_sel sequence 0,1,2,3,0…; out_data 10,11,12,13; one beat/cycle.
- in_valid=4'b0100 only, out_ready=1 -> ch2 granted every cycle, in_ready=4'b0100 continuously, no bubbles.
- Stream running, out_ready=0 for 3 cycles -> out_valid=1, out_data stable, in_ready=0; on release, transfer resumes with the next round-robin channel, with no loss or duplication.
- Grant ch1, then idle 5 cycles, then in_valid=4'b1011 -> ch3 granted first (last_grant held at 1).
- Assert rst while out_valid=1 and ch2 pending -> out_valid=0 asynchronously; after release with in_valid=4'b0101, ch0 is granted first.
- With MUX_RR_SEL_OVERRIDE_EN defined, force_en=1, force_sel=3, in_valid=4'b1111 -> only ch3 is accepted each cycle. With force_sel=3 and in_valid[3]=0 -> nothing is accepted.
